// File: rtl/wb_uart_rx.sv
// 8N1 UART receiver with a Wishbone B4 classic register port and receive FIFO.
// Define WB_UART_RX_IRQ_EN to add the CTRL register and the irq output.
module wb_uart_rx #(
   parameter int CLKS_PER_BIT = 208,
   parameter int FIFO_DEPTH   = 16
) (
`ifdef WB_UART_RX_IRQ_EN
   output logic        irq,
   input  logic [3:0]  wb_adr_i,
`else
   input  logic [2:0]  wb_adr_i,
`endif
   input  logic        clock,
   input  logic        reset,
   input  logic        uart_rx,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   output logic        wb_ack_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [15:0] CNT_HALF = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] CNT_FULL = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;

   logic          rx_meta_q, rx_s_q;
   state_t        state_q, state_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovr_q, ovr_d, ferr_q, ferr_d;
   logic          ack_q, ack_d, pop_pend_q, pop_pend_d;
   logic [31:0]   dat_q, dat_d;
   logic [7:0]    fifo_mem [FIFO_DEPTH];

   logic          tick, push_req, ferr_set, push_ok, ovr_set, pop;
   logic          req, empty, full, clr_wr;
   logic [1:0]    reg_sel;
   logic [8:0]    count_ext;
   logic [7:0]    level8;
   logic [31:0]   status_word;
   logic          unused_ok;

`ifdef WB_UART_RX_IRQ_EN
   logic rxie_q, rxie_d, errie_q, errie_d, irq_q, irq_d;
   assign reg_sel = wb_adr_i[3:2];
   assign irq     = irq_q;
`else
   assign reg_sel = {1'b0, wb_adr_i[2]};
`endif

   assign unused_ok = ^{wb_sel_i, wb_dat_i, wb_adr_i};

   assign tick        = (cnt_q == 16'd0);
   assign empty       = (count_q == '0);
   assign full        = (count_q == CW'(FIFO_DEPTH));
   assign count_ext   = 9'(count_q);
   assign level8      = count_ext[8] ? 8'hFF : count_ext[7:0];
   assign status_word = {16'b0, level8, 4'b0, ferr_q, ovr_q, full, ~empty};
   assign req         = wb_cyc_i & wb_stb_i & ~ack_q;
   assign clr_wr      = req & wb_we_i & (reg_sel == 2'd1);
   assign pop         = pop_pend_q;

   // Receive FSM: half-bit delay to the centre of the start bit, then whole bits.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      push_req  = 1'b0;
      ferr_set  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rx_s_q) begin
               cnt_d   = CNT_HALF;
               state_d = S_START;
            end
         end
         S_START: begin
            if (!tick) cnt_d = cnt_q - 16'd1;
            else if (rx_s_q) state_d = S_IDLE;
            else begin
               cnt_d     = CNT_FULL;
               bit_idx_d = 3'd0;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (!tick) cnt_d = cnt_q - 16'd1;
            else begin
               shreg_d   = {rx_s_q, shreg_q[7:1]};
               cnt_d     = CNT_FULL;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (!tick) cnt_d = cnt_q - 16'd1;
            else if (rx_s_q) begin
               push_req = 1'b1;
               state_d  = S_IDLE;
            end else begin
               ferr_set = 1'b1;
               state_d  = S_WAIT_HIGH;
            end
         end
         S_WAIT_HIGH: if (rx_s_q) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FIFO, sticky flags and bus side; a pop in the same cycle frees room for a push.
   always_comb begin
      push_ok    = push_req & (~full | pop);
      ovr_set    = push_req & full & ~pop;
      wr_ptr_d   = wr_ptr_q + AW'(push_ok);
      rd_ptr_d   = rd_ptr_q + AW'(pop);
      count_d    = count_q + CW'(push_ok) - CW'(pop);
      ovr_d      = ovr_set  | (ovr_q  & ~(clr_wr & wb_dat_i[2]));
      ferr_d     = ferr_set | (ferr_q & ~(clr_wr & wb_dat_i[3]));
      ack_d      = req;
      pop_pend_d = req & ~wb_we_i & (reg_sel == 2'd0) & ~empty;
      dat_d      = dat_q;
      if (req && !wb_we_i) begin
         case (reg_sel)
            2'd0:    dat_d = empty ? 32'd0 : {24'b0, fifo_mem[rd_ptr_q]};
            2'd1:    dat_d = status_word;
`ifdef WB_UART_RX_IRQ_EN
            2'd2:    dat_d = {30'b0, errie_q, rxie_q};
`endif
            default: dat_d = 32'd0;
         endcase
      end
`ifdef WB_UART_RX_IRQ_EN
      rxie_d  = rxie_q;
      errie_d = errie_q;
      if (req && wb_we_i && reg_sel == 2'd2) begin
         rxie_d  = wb_dat_i[0];
         errie_d = wb_dat_i[1];
      end
      irq_d = (rxie_q & ~empty) | (errie_q & (ovr_q | ferr_q));
`endif
   end

   always_ff @(posedge clock) begin
      if (push_ok) fifo_mem[wr_ptr_q] <= shreg_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_meta_q  <= 1'b1;
         rx_s_q     <= 1'b1;
         state_q    <= S_IDLE;
         cnt_q      <= 16'd0;
         bit_idx_q  <= 3'd0;
         shreg_q    <= 8'd0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovr_q      <= 1'b0;
         ferr_q     <= 1'b0;
         ack_q      <= 1'b0;
         pop_pend_q <= 1'b0;
         dat_q      <= 32'd0;
`ifdef WB_UART_RX_IRQ_EN
         rxie_q     <= 1'b0;
         errie_q    <= 1'b0;
         irq_q      <= 1'b0;
`endif
      end else begin
         rx_meta_q  <= uart_rx;
         rx_s_q     <= rx_meta_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         shreg_q    <= shreg_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovr_q      <= ovr_d;
         ferr_q     <= ferr_d;
         ack_q      <= ack_d;
         pop_pend_q <= pop_pend_d;
         dat_q      <= dat_d;
`ifdef WB_UART_RX_IRQ_EN
         rxie_q     <= rxie_d;
         errie_q    <= errie_d;
         irq_q      <= irq_d;
`endif
      end
   end

   assign wb_ack_o = ack_q;
   assign wb_dat_o = dat_q;
endmodule
